// File: rtl/netled_pkg.sv
// Shared definitions for the Ethernet link/activity LED driver.
package netled_pkg;

  // Width of the per-channel tick countdown.
  localparam int NL_CNTW = 8;

  // Per-channel blink state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } nl_state_e;

  // A configured duration of zero ticks is promoted to one tick.
  function automatic logic [NL_CNTW-1:0] nl_min1(input logic [NL_CNTW-1:0] v);
    logic [NL_CNTW-1:0] r;
    if (v == {NL_CNTW{1'b0}}) begin
      r = {{(NL_CNTW-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/netled_chan.sv
// One activity-LED channel: IDLE/ON/OFF blink sequencer with a tick
// countdown and a single-bit "another blink wanted" flag.
module netled_chan
  import netled_pkg::*;
#(
  parameter logic [NL_CNTW-1:0] ON_TICKS  = 8'd50,
  parameter logic [NL_CNTW-1:0] OFF_TICKS = 8'd50
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic ev,
  input  logic link_up,
  output logic led_on
);

  localparam logic [NL_CNTW-1:0] ON_EFF  = nl_min1(ON_TICKS);
  localparam logic [NL_CNTW-1:0] OFF_EFF = nl_min1(OFF_TICKS);
  localparam logic [NL_CNTW-1:0] CNT_ONE = {{(NL_CNTW-1){1'b0}}, 1'b1};

  nl_state_e            state_r, state_s;
  logic [NL_CNTW-1:0]   count_r, count_s;
  logic                 pending_r, pending_s;

  // Next-state, countdown and pending-flag computation.
  always_comb begin
    state_s   = state_r;
    count_s   = count_r;
    pending_s = pending_r;
    if (!link_up) begin
      // Link loss abandons any blink in progress and any queued one.
      state_s   = ST_IDLE;
      count_s   = {NL_CNTW{1'b0}};
      pending_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ev) begin
            // The tick on this cycle (if any) is not counted.
            state_s   = ST_ON;
            count_s   = ON_EFF;
            pending_s = 1'b0;
          end else begin
            state_s   = ST_IDLE;
          end
        end
        ST_ON: begin
          pending_s = pending_r | ev;
          if (tick && (count_r == CNT_ONE)) begin
            state_s = ST_OFF;
            count_s = OFF_EFF;
          end else if (tick) begin
            count_s = count_r - CNT_ONE;
          end else begin
            count_s = count_r;
          end
        end
        ST_OFF: begin
          if (tick && (count_r == CNT_ONE)) begin
            // Gap expired: an event on this very cycle also restarts.
            if (pending_r || ev) begin
              state_s   = ST_ON;
              count_s   = ON_EFF;
              pending_s = 1'b0;
            end else begin
              state_s   = ST_IDLE;
              count_s   = {NL_CNTW{1'b0}};
              pending_s = 1'b0;
            end
          end else if (tick) begin
            count_s   = count_r - CNT_ONE;
            pending_s = pending_r | ev;
          end else begin
            pending_s = pending_r | ev;
          end
        end
        default: begin
          state_s   = ST_IDLE;
          count_s   = {NL_CNTW{1'b0}};
          pending_s = 1'b0;
        end
      endcase
    end
  end

  assign led_on = (state_s == ST_ON);

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      count_r   <= {NL_CNTW{1'b0}};
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      pending_r <= pending_s;
    end
  end

endmodule

// File: rtl/netled_status.sv
// Per-port 10GbE link/activity LED driver: shared fractional timebase,
// one blink sequencer per port, lamp-test override and output registers.
module netled_status
  import netled_pkg::*;
#(
  parameter int                 NLINKS    = 4,
  parameter logic [31:0]        TICK_STEP = 32'd42950,
  parameter logic [NL_CNTW-1:0] ON_TICKS  = 8'd50,
  parameter logic [NL_CNTW-1:0] OFF_TICKS = 8'd50
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NLINKS-1:0] i_link_up,
  input  logic [NLINKS-1:0] i_rx_stb,
  input  logic [NLINKS-1:0] i_tx_stb,
  input  logic              i_lamp_test,
  output logic [NLINKS-1:0] o_linkup,
  output logic [NLINKS-1:0] o_activity
);

  logic [31:0]       acc_r;
  logic              tick_r;
  logic [NLINKS-1:0] ev_s;
  logic [NLINKS-1:0] led_on_s;

  // Strobes only count while the port's link is up.
  assign ev_s = (i_rx_stb | i_tx_stb) & i_link_up;

  // Fractional accumulator; its carry-out is the one-cycle tick.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc_r  <= 32'd0;
      tick_r <= 1'b0;
    end else begin
      {tick_r, acc_r} <= {1'b0, acc_r} + {1'b0, TICK_STEP};
    end
  end

  for (genvar k = 0; k < NLINKS; k++) begin : g_chan
    netled_chan #(
      .ON_TICKS (ON_TICKS),
      .OFF_TICKS(OFF_TICKS)
    ) u_chan (
      .clk    (i_clk),
      .reset  (i_reset),
      .tick   (tick_r),
      .ev     (ev_s[k]),
      .link_up(i_link_up[k]),
      .led_on (led_on_s[k])
    );
  end

  // LED output registers with lamp-test override.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_linkup   <= {NLINKS{1'b0}};
      o_activity <= {NLINKS{1'b0}};
    end else if (i_lamp_test) begin
      o_linkup   <= {NLINKS{1'b1}};
      o_activity <= {NLINKS{1'b1}};
    end else begin
      o_linkup   <= i_link_up;
      o_activity <= led_on_s;
    end
  end

endmodule

// File: tb/tb_netled_status.sv
// Scoreboard bench for netled_status: a tick-count reference model predicts
// each cycle's LEDs and tick; a negedge monitor compares against the DUT.
module tb_netled_status;

  localparam int     NL     = 4;
  localparam int     ON_T   = 3;
  localparam int     OFF_T  = 2;
  localparam longint STEP_L = 64'h4000_0000;

  localparam int M_IDLE = 0;
  localparam int M_LIT  = 1;
  localparam int M_DARK = 2;

  typedef struct {
    logic [NL-1:0] lk;
    logic [NL-1:0] act;
    logic          tk;
    longint        cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NL-1:0] link = '0;
  logic [NL-1:0] rx = '0;
  logic [NL-1:0] tx = '0;
  logic          lamp = 1'b0;
  logic [NL-1:0] o_linkup;
  logic [NL-1:0] o_activity;

  exp_t   sb_q[$];
  int     vectors = 0;
  int     miscompares = 0;

  // Reference model: blink windows measured in absolute tick counts.
  int     m_mode[NL];
  longint m_base[NL];
  bit     m_pend[NL];
  longint m_cyc = 0;
  longint gcyc = 0;

  netled_status #(
    .NLINKS   (NL),
    .TICK_STEP(32'h4000_0000),
    .ON_TICKS (8'd3),
    .OFF_TICKS(8'd2)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_link_up  (link),
    .i_rx_stb   (rx),
    .i_tx_stb   (tx),
    .i_lamp_test(lamp),
    .o_linkup   (o_linkup),
    .o_activity (o_activity)
  );

  always #5 clk = ~clk;

  // Ticks observed in cycles 1..c after reset release.
  function automatic longint kfun(input longint c);
    return (c * STEP_L) >>> 32;
  endfunction

  function automatic bit off_expiring(input int k);
    return (m_mode[k] == M_DARK) && (kfun(m_cyc) - m_base[k] >= OFF_T) && link[k];
  endfunction

  // Apply current inputs for one clock, predicting the next cycle's outputs.
  task automatic drive_cycle();
    exp_t   e;
    longint kc;
    longint nxt;
    bit     ev;
    kc = kfun(m_cyc);
    if (rst) begin
      for (int k = 0; k < NL; k++) begin
        m_mode[k] = M_IDLE;
        m_pend[k] = 1'b0;
      end
      nxt = 0;
    end else begin
      for (int k = 0; k < NL; k++) begin
        ev = (rx[k] | tx[k]) & link[k];
        if (!link[k]) begin
          m_mode[k] = M_IDLE;
          m_pend[k] = 1'b0;
        end else if (m_mode[k] == M_IDLE) begin
          if (ev) begin
            m_mode[k] = M_LIT;
            m_base[k] = kc;
          end
        end else if (m_mode[k] == M_LIT) begin
          if (ev) m_pend[k] = 1'b1;
          if (kc - m_base[k] >= ON_T) begin
            m_mode[k] = M_DARK;
            m_base[k] = kc;
          end
        end else begin
          if (kc - m_base[k] >= OFF_T) begin
            if (m_pend[k] || ev) begin
              m_mode[k] = M_LIT;
              m_base[k] = kc;
              m_pend[k] = 1'b0;
            end else begin
              m_mode[k] = M_IDLE;
            end
          end else if (ev) begin
            m_pend[k] = 1'b1;
          end
        end
      end
      nxt = m_cyc + 1;
    end
    e.tk = (nxt >= 1) ? ((kfun(nxt) - kfun(nxt - 1)) != 0) : 1'b0;
    for (int k = 0; k < NL; k++) begin
      e.lk[k]  = rst ? 1'b0 : (lamp | link[k]);
      e.act[k] = rst ? 1'b0 : (lamp | (m_mode[k] == M_LIT));
    end
    gcyc  = gcyc + 1;
    e.cyc = gcyc;
    sb_q.push_back(e);
    m_cyc = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle();
  endtask

  task automatic check_bound(input bit ok, input string name);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: wait bound expired (got timeout, required event)", name);
    end
  endtask

  // Monitor: pop one prediction per cycle and compare with the DUT.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      vectors++;
      if (o_linkup !== e.lk || o_activity !== e.act || dut.tick_r !== e.tk) begin
        miscompares++;
        $display("FAIL cycle %0d: linkup=%b act=%b tick=%b, required linkup=%b act=%b tick=%b",
                 e.cyc, o_linkup, o_activity, dut.tick_r, e.lk, e.act, e.tk);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < NL; k++) begin
      m_mode[k] = M_IDLE;
      m_base[k] = 0;
      m_pend[k] = 1'b0;
    end

    // Reset, then quiet idle.
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(100);

    // Single receive blink on port 2.
    link[2] = 1'b1;
    idle(3);
    rx[2] = 1'b1; drive_cycle(); rx[2] = 1'b0;
    idle(30);

    // Continuous transmit traffic on port 0.
    link = 4'hF;
    tx[0] = 1'b1;
    idle(80);
    tx[0] = 1'b0;
    idle(25);

    // Port 3: strobe during OFF gives exactly one more blink.
    rx[3] = 1'b1; drive_cycle(); rx[3] = 1'b0;
    n = 0;
    while (m_mode[3] != M_DARK && n < 40) begin drive_cycle(); n++; end
    check_bound(m_mode[3] == M_DARK, "port3_reach_off");
    tx[3] = 1'b1; drive_cycle(); tx[3] = 1'b0;
    idle(40);

    // Port 3: strobe exactly on the OFF expiry cycle.
    rx[3] = 1'b1; drive_cycle(); rx[3] = 1'b0;
    n = 0;
    while (!off_expiring(3) && n < 60) begin drive_cycle(); n++; end
    check_bound(off_expiring(3), "port3_off_expiry");
    rx[3] = 1'b1; drive_cycle(); rx[3] = 1'b0;
    idle(40);

    // Port 1: link drop mid-ON, strobes while down, recovery.
    rx[1] = 1'b1; drive_cycle(); rx[1] = 1'b0;
    idle(4);
    link[1] = 1'b0; rx[1] = 1'b1; drive_cycle(); rx[1] = 1'b0;
    idle(2);
    tx[1] = 1'b1; drive_cycle(); tx[1] = 1'b0;
    idle(3);
    link[1] = 1'b1;
    idle(2);
    rx[1] = 1'b1; drive_cycle(); rx[1] = 1'b0;
    idle(20);

    // Randomised traffic with lamp test and a mid-blink reset.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < NL; k++) begin
        link[k] = ($urandom_range(0, 39) != 0);
        rx[k]   = ($urandom_range(0, 7) == 0);
        tx[k]   = ($urandom_range(0, 7) == 0);
      end
      lamp = (i >= 100) && (i < 110);
      rst  = (i == 200);
      drive_cycle();
    end
    rst  = 1'b0;
    lamp = 1'b0;
    rx   = '0;
    tx   = '0;
    link = 4'hF;
    idle(40);

    // Final reset with everything quiet.
    rst = 1'b1; drive_cycle(); rst = 1'b0;
    idle(10);

    n = 0;
    while (sb_q.size() > 0 && n < 5) begin @(negedge clk); #1; n++; end
    check_bound(sb_q.size() == 0, "scoreboard_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/netled_status.md
Name: netled_status

Overview:
- Operational driver for the per-port 10Gb Ethernet link and activity LEDs. Replaces the demonstration LED sequencer.
- Consumes live link-state levels and per-packet RX/TX strobes from the port logic.
- Produces `o_linkup` (solid while the link is up) and `o_activity`. Activity is a blink stretched to a visible length, with an enforced off gap so that continuous traffic reads as blinking.
- Sits between the per-port MAC/PCS status and the board LED pins.

Parameters:
- NLINKS, 4, number of ports/LED pairs.
- TICK_STEP, 32'd42950, fractional step added each clock to a 32-bit accumulator; carry-out is the timebase tick (about 1 ms at 100 MHz).
- ON_TICKS, 8'd50, ticks the activity LED stays lit per blink; 0 is treated as 1.
- OFF_TICKS, 8'd50, minimum dark ticks between blinks; 0 is treated as 1.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  synchronous, active-high reset
- i_link_up  input  NLINKS  per-port link-established level
- i_rx_stb  input  NLINKS  one-cycle pulse per received packet
- i_tx_stb  input  NLINKS  one-cycle pulse per transmitted packet
- i_lamp_test  input  1  level; forces every LED on
- o_linkup  output  NLINKS  registered link LED drive
- o_activity  output  NLINKS  registered activity LED drive

Behaviour:
- Interface: one clock, `i_clk`. Reset `i_reset` is synchronous and active-high. Reset has priority over every other event.
- On reset:
  - accumulator = 0, tick = 0;
  - every channel goes to IDLE with count = 0 and pending = 0;
  - `o_linkup` = 0, `o_activity` = 0.
- Timebase: each cycle `{tick, acc} <= acc + TICK_STEP`. The tick is high for exactly one cycle per carry and is shared by all channels.
- Link LED: `o_linkup[k] <= i_link_up[k]`, so latency is 1 cycle.
- Event definition: `ev[k] = (i_rx_stb[k] | i_tx_stb[k]) & i_link_up[k]`. Strobes arriving while the link is down are dropped.
- Per-channel FSM, states IDLE, ON, OFF:
  - IDLE: if `ev`, go to ON with count = ON_TICKS.
  - ON: on a tick, decrement count. When a tick arrives with count == 1, go to OFF with count = OFF_TICKS.
  - OFF: on a tick, decrement count. When a tick arrives with count == 1: go to ON (count = ON_TICKS, pending cleared) if pending or `ev` is set; otherwise go to IDLE.
  - In ON or OFF, `ev` sets pending. Pending is a single bit and does not count events; any number of events during a blink produce exactly one follow-on blink.
- Activity output:
  - `o_activity[k] <= (next state == ON)`, so the LED lights 1 cycle after the triggering strobe.
  - ON duration is between (ON_TICKS-1) tick periods + 1 cycle and ON_TICKS tick periods, because the first tick is asynchronous to the event.
- Link drop: if `i_link_up[k]` is 0 in any state, next state is IDLE, pending is cleared, and `o_activity[k]` is 0 on the next cycle.
- Lamp test: while `i_lamp_test` = 1, `o_linkup` and `o_activity` are all-ones (1-cycle latency). The FSMs and timebase keep running underneath. On release, outputs show live state on the next cycle.
- Simultaneous events:
  - `ev` on the same cycle as OFF expiry starts a new ON.
  - `ev` on the same cycle as link drop is ignored.
  - A tick on the same cycle as entry into ON does not decrement; the count starts on the following tick.
- Reset mid-blink: reset returns the channel to IDLE with outputs 0 on the next edge; no residual pending.

Decomposition:
- Package `netled_pkg`: 2-bit state encodings `ST_IDLE`, `ST_ON`, `ST_OFF`; count width constant `NL_CNTW` = 8.
- Sub-module `netled_chan`: one FSM with count and pending, generated NLINKS times. It takes `tick`, `ev`, `link_up` and `reset`, and returns the `led_on` next-state.
- Top level holds the timebase accumulator, the lamp-test mux and the output registers.

Test Plan:
- Bench setup: TICK_STEP = 32'h4000_0000 (tick every 4 cycles), ON_TICKS = 3, OFF_TICKS = 2.
- Reset then idle 100 cycles -> all outputs 0; tick period exactly 4 cycles.
- Link up on port 2, single `i_rx_stb[2]` pulse -> `o_linkup[2]` = 1 one cycle after link-up; `o_activity[2]` = 1 from strobe+1 for 9–12 cycles; then 0 and stays 0; other ports unaffected.
- Continuous `i_tx_stb[0]` every cycle with link up -> `o_activity[0]` alternates ON 9–12 cycles / OFF 5–8 cycles with no ON run exceeding 12 cycles.
- Strobe during OFF, then none -> exactly one more blink, then IDLE; strobe exactly on the OFF expiry cycle -> ON begins with no idle cycle.
- Link drop mid-ON on port 1 -> `o_linkup[1]` and `o_activity[1]` = 0 next cycle; strobes while down produce no blink; after link returns, the first strobe blinks normally.
- `i_lamp_test` pulsed for 10 cycles during traffic, then reset asserted mid-blink -> outputs all 1 for those 10 cycles (1-cycle latency); after reset, all outputs 0 and every FSM IDLE.
